// File: rtl/mc_pkg.sv
// mc_pkg: shared types, operation encodings and DDR5 address field positions
// for the memory-controller request queue and scheduler.
package mc_pkg;

  localparam int MC_DEPTH_DEF = 16;
  localparam int MC_TIME_W    = 32;
  localparam int MC_ADDR_W    = 34;
  localparam int MC_CORE_W    = 4;
  localparam int MC_OP_W      = 2;

  // Request operation encoding; OP_ILLEGAL is never forwarded downstream.
  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_IFETCH  = 2'd2,
    OP_ILLEGAL = 2'd3
  } mc_op_e;

  // Address field positions (LSB and width of each decoded field)
  localparam int CH_BIT     = 6;
  localparam int BG_LSB     = 7;
  localparam int BG_W       = 3;
  localparam int BANK_LSB   = 10;
  localparam int BANK_W     = 2;
  localparam int ROW_LSB    = 18;
  localparam int ROW_W      = 16;
  localparam int COL_HI_LSB = 12;
  localparam int COL_HI_W   = 6;
  localparam int COL_LO_LSB = 2;
  localparam int COL_LO_W   = 4;
  localparam int COL_W      = COL_HI_W + COL_LO_W;

  // One buffered request as exchanged with the scheduler
  typedef struct packed {
    logic [MC_CORE_W-1:0] core;
    logic [MC_TIME_W-1:0] req_time;
    logic [MC_OP_W-1:0]   op;
    logic [MC_ADDR_W-1:0] addr;
  } mem_req_t;

  // True for operations the scheduler can execute
  function automatic logic is_legal_op(input logic [MC_OP_W-1:0] op);
    return (op != OP_ILLEGAL);
  endfunction

endpackage

// File: rtl/mc_addr_map.sv
// mc_addr_map: purely combinational physical address to DDR5
// channel / bank group / bank / row / column decode.
module mc_addr_map
  import mc_pkg::*;
(
  input  logic [MC_ADDR_W-1:0] i_addr,
  output logic                 o_channel,
  output logic [BG_W-1:0]      o_bg,
  output logic [BANK_W-1:0]    o_bank,
  output logic [ROW_W-1:0]     o_row,
  output logic [COL_W-1:0]     o_col
);

  // Slice the address into DRAM coordinates; bits [1:0] are the byte offset
  // inside a beat and carry no scheduling information.
  always_comb begin
    o_channel = i_addr[CH_BIT];
    o_bg      = i_addr[BG_LSB +: BG_W];
    o_bank    = i_addr[BANK_LSB +: BANK_W];
    o_row     = i_addr[ROW_LSB +: ROW_W];
    o_col     = {i_addr[COL_HI_LSB +: COL_HI_W], i_addr[COL_LO_LSB +: COL_LO_W]};
  end

endmodule

// File: rtl/mc_request_queue.sv
// mc_request_queue: in-order ingress FIFO in front of the DDR5 scheduler.
// Buffers DEPTH requests, drops illegal ops with a one-cycle err_op pulse and
// presents the decoded head request over a valid/ready handshake.
// Optional build macro: MCQ_TIME_GATE_EN holds the head back until
// cycle_count >= request time + 2.
module mc_request_queue
  import mc_pkg::*;
#(
  parameter int DEPTH  = MC_DEPTH_DEF,
  parameter int TIME_W = MC_TIME_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_core,
  input  logic [TIME_W-1:0]         in_time,
  input  logic [1:0]                in_op,
  input  logic [33:0]               in_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0]                out_core,
  output logic [TIME_W-1:0]         out_time,
  output logic [1:0]                out_op,
  output logic                      out_channel,
  output logic [2:0]                out_bg,
  output logic [1:0]                out_bank,
  output logic [15:0]               out_row,
  output logic [9:0]                out_col,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err_op,
  output logic [63:0]               cycle_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage (deliberately not reset)
  logic [MC_CORE_W-1:0] r_core [DEPTH];
  logic [TIME_W-1:0]    r_time [DEPTH];
  logic [MC_OP_W-1:0]   r_op   [DEPTH];
  logic [MC_ADDR_W-1:0] r_addr [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err_op;
  logic [63:0]      r_cycle_count;

  logic w_full;
  logic w_empty;
  logic w_offer;
  logic w_drop;
  logic w_push;
  logic w_pop;
  logic w_eligible;

  // Occupancy flags and handshake qualification
  always_comb begin
    w_full  = (r_count == FULL_CNT);
    w_empty = (r_count == {CNT_W{1'b0}});
    w_offer = in_valid & ~w_full;
    w_drop  = w_offer & ~is_legal_op(in_op);
    w_push  = w_offer & is_legal_op(in_op);
    w_pop   = out_valid & out_ready;
  end

  // Head eligibility: optionally wait for the trace request time to elapse
  always_comb begin
`ifdef MCQ_TIME_GATE_EN
    w_eligible = (r_cycle_count >= (64'(r_time[r_rd_ptr]) + 64'd2));
`else
    w_eligible = 1'b1;
`endif
  end

  // Pointers, occupancy, error pulse and free-running cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr      <= {PTR_W{1'b0}};
      r_rd_ptr      <= {PTR_W{1'b0}};
      r_count       <= {CNT_W{1'b0}};
      r_err_op      <= 1'b0;
      r_cycle_count <= 64'd0;
    end else begin
      r_cycle_count <= r_cycle_count + 64'd1;
      r_err_op      <= w_drop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1'b1);
        2'b01:   r_count <= r_count - CNT_W'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write an accepted legal request into the slot at the write pointer
  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_core[r_wr_ptr] <= in_core;
      r_time[r_wr_ptr] <= in_time;
      r_op[r_wr_ptr]   <= in_op;
      r_addr[r_wr_ptr] <= in_addr;
    end
  end

  mc_addr_map u_addr_map (
    .i_addr    (r_addr[r_rd_ptr]),
    .o_channel (out_channel),
    .o_bg      (out_bg),
    .o_bank    (out_bank),
    .o_row     (out_row),
    .o_col     (out_col)
  );

  assign in_ready    = ~w_full;
  assign out_valid   = ~w_empty & w_eligible;
  assign out_core    = r_core[r_rd_ptr];
  assign out_time    = r_time[r_rd_ptr];
  assign out_op      = r_op[r_rd_ptr];
  assign count       = r_count;
  assign err_op      = r_err_op;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mc_request_queue.sv
// tb_mc_request_queue: self-checking bench with a queue-based reference model.
module tb_mc_request_queue;

  localparam int DEPTH  = 16;
  localparam int TIME_W = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_core = 4'd0;
  logic [TIME_W-1:0] in_time = 32'd0;
  logic [1:0]        in_op = 2'd0;
  logic [33:0]       in_addr = 34'd0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [3:0]        out_core;
  logic [TIME_W-1:0] out_time;
  logic [1:0]        out_op;
  logic              out_channel;
  logic [2:0]        out_bg;
  logic [1:0]        out_bank;
  logic [15:0]       out_row;
  logic [9:0]        out_col;
  logic [4:0]        count;
  logic              err_op;
  logic [63:0]       cycle_count;

  mc_request_queue #(.DEPTH(DEPTH), .TIME_W(TIME_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_core(in_core),
    .in_time(in_time), .in_op(in_op), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_core(out_core),
    .out_time(out_time), .out_op(out_op), .out_channel(out_channel),
    .out_bg(out_bg), .out_bank(out_bank), .out_row(out_row), .out_col(out_col),
    .count(count), .err_op(err_op), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  core;
    logic [31:0] t;
    logic [1:0]  op;
    logic [33:0] addr;
  } req_t;

  req_t q[$];
  longint unsigned m_cc = 0;
  bit m_err = 1'b0;

  function automatic bit m_elig(input logic [31:0] t);
`ifdef MCQ_TIME_GATE_EN
    return (m_cc >= (64'(t) + 64'd2));
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit m_out_valid();
    return (q.size() != 0) && m_elig(q[0].t);
  endfunction

  function automatic bit m_in_ready();
    return (q.size() < DEPTH);
  endfunction

  function automatic logic       exp_ch  (input logic [33:0] a); return 1'((a >> 6) % 2);  endfunction
  function automatic logic [2:0] exp_bg  (input logic [33:0] a); return 3'((a >> 7) % 8);  endfunction
  function automatic logic [1:0] exp_bank(input logic [33:0] a); return 2'((a >> 10) % 4); endfunction
  function automatic logic [15:0] exp_row(input logic [33:0] a); return 16'(a >> 18);      endfunction
  function automatic logic [9:0] exp_col (input logic [33:0] a);
    return 10'(((a >> 12) % 64) * 16 + ((a >> 2) % 16));
  endfunction

  // Advance one clock, updating the reference model from the driven inputs.
  task automatic step();
    bit push, pop, ill;
    req_t e;
    if (reset) begin
      @(posedge clock);
      q.delete();
      m_cc = 0;
      m_err = 1'b0;
    end else begin
      ill  = in_valid && m_in_ready() && (in_op == 2'd3);
      push = in_valid && m_in_ready() && (in_op != 2'd3);
      pop  = m_out_valid() && out_ready;
      e = '{core: in_core, t: in_time, op: in_op, addr: in_addr};
      @(posedge clock);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      m_err = ill;
      m_cc++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_op = 2'd0;
    step(); step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (err_op !== 1'b0) begin failures++; $display("FAIL reset_err_op got=%0b exp=0", err_op); end
    checks++; if (cycle_count !== 64'd0) begin failures++; $display("FAIL reset_cycle_count got=%0d exp=0", cycle_count); end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    checks++; if (cycle_count !== m_cc) begin failures++; $display("FAIL cycle_count_after_reset got=%0d exp=%0d", cycle_count, m_cc); end
  endtask

  task automatic test_decode();
    in_valid = 1'b1; in_op = 2'd0; in_time = 32'd0; in_core = 4'd3; in_addr = 34'h2_3456_7ABC;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== m_out_valid()) begin failures++; $display("FAIL decode_out_valid got=%0b exp=%0b", out_valid, m_out_valid()); end
    checks++; if (out_bg !== 3'h5) begin failures++; $display("FAIL decode_bg got=%h exp=5", out_bg); end
    checks++; if (out_bank !== 2'h2) begin failures++; $display("FAIL decode_bank got=%h exp=2", out_bank); end
    checks++; if (out_row !== 16'h8D15) begin failures++; $display("FAIL decode_row got=%h exp=8d15", out_row); end
    checks++; if (out_channel !== 1'b0) begin failures++; $display("FAIL decode_channel got=%b exp=0", out_channel); end
    checks++; if (out_col !== exp_col(q[0].addr)) begin failures++; $display("FAIL decode_col got=%h exp=%h", out_col, exp_col(q[0].addr)); end
    checks++; if (out_core !== 4'd3) begin failures++; $display("FAIL decode_core got=%0d exp=3", out_core); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 5'(q.size())) begin failures++; $display("FAIL decode_pop_count got=%0d exp=%0d", count, q.size()); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_op = 2'($urandom_range(0, 2)); in_time = 32'd0;
      in_core = 4'($urandom); in_addr = {2'($urandom_range(0, 3)), 32'($urandom)};
      step();
    end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
    in_addr = 34'h1_0000_0000;
    step();
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL full_17th_ignored got=%0d exp=16", count); end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 5'd15) begin failures++; $display("FAIL full_pop_only got=%0d exp=15", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_in_ready_after_pop got=%0b exp=1", in_ready); end
    checks++; if (out_row !== exp_row(q[0].addr) || out_core !== q[0].core) begin
      failures++; $display("FAIL full_head got_row=%h exp_row=%h got_core=%0d exp_core=%0d", out_row, exp_row(q[0].addr), out_core, q[0].core);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    out_ready = 1'b0;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL full_drain got=%0d exp=0", count); end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_op = 2'd3; in_addr = 34'h0_1234_5678; in_time = 32'd0;
    step();
    in_valid = 1'b0; in_op = 2'd0;
    checks++; if (err_op !== 1'b1) begin failures++; $display("FAIL illegal_err_op got=%0b exp=1", err_op); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL illegal_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL illegal_out_valid got=%0b exp=0", out_valid); end
    step();
    checks++; if (err_op !== 1'b0) begin failures++; $display("FAIL illegal_err_pulse_len got=%0b exp=0", err_op); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 2'd1; in_time = 32'd0; in_addr = 34'(i * 64);
      step();
    end
    reset = 1'b1; out_ready = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid got count=%0d valid=%0b ready=%0b exp 0/0/1", count, out_valid, in_ready);
    end
    checks++; if (cycle_count !== 64'd0) begin failures++; $display("FAIL reset_mid_cycle got=%0d exp=0", cycle_count); end
  endtask

  task automatic test_time_gate();
    longint unsigned rise_cc = 0;
    longint unsigned exp_rise;
    bit seen = 1'b0;
`ifdef MCQ_TIME_GATE_EN
    exp_rise = 102;
`else
    exp_rise = 11;
`endif
    for (int i = 0; i < 20 && m_cc < 10; i++) step();
    in_valid = 1'b1; in_op = 2'd2; in_time = 32'd100; in_addr = 34'h3_FFFF_FFFC; in_core = 4'hA;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin
      checks++; if (out_valid !== m_out_valid()) begin failures++; $display("FAIL gate_out_valid cc=%0d got=%0b exp=%0b", m_cc, out_valid, m_out_valid()); end
      if (out_valid === 1'b1) begin seen = 1'b1; rise_cc = cycle_count; end
      else step();
    end
    checks++; if (!seen || rise_cc != exp_rise) begin failures++; $display("FAIL gate_rise_cycle got=%0d exp=%0d seen=%0b", rise_cc, exp_rise, seen); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random_wrap();
    int pushed = 0;
    bit done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      checks++; if (count !== 5'(q.size()) || in_ready !== m_in_ready() || out_valid !== m_out_valid()) begin
        failures++; $display("FAIL rand_ctrl cyc=%0d count=%0d/%0d ready=%0b/%0b valid=%0b/%0b", cyc, count, q.size(), in_ready, m_in_ready(), out_valid, m_out_valid());
      end
      checks++; if (err_op !== m_err || cycle_count !== m_cc) begin
        failures++; $display("FAIL rand_err_cc cyc=%0d err=%0b/%0b cc=%0d/%0d", cyc, err_op, m_err, cycle_count, m_cc);
      end
      if (m_out_valid()) begin
        checks++;
        if (out_core !== q[0].core || out_time !== q[0].t || out_op !== q[0].op ||
            out_channel !== exp_ch(q[0].addr) || out_bg !== exp_bg(q[0].addr) ||
            out_bank !== exp_bank(q[0].addr) || out_row !== exp_row(q[0].addr) || out_col !== exp_col(q[0].addr)) begin
          failures++; $display("FAIL rand_head cyc=%0d core=%0d/%0d op=%0d/%0d row=%h/%h col=%h/%h", cyc, out_core, q[0].core, out_op, q[0].op, out_row, exp_row(q[0].addr), out_col, exp_col(q[0].addr));
        end
      end
      if (pushed >= 24 && q.size() == 0) begin
        done = 1'b1;
      end else begin
        in_valid  = (pushed < 24) && ($urandom_range(0, 9) < 7);
        in_op     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        in_time   = 32'($urandom_range(0, 32'(m_cc) + 4));
        in_core   = 4'($urandom);
        in_addr   = {2'($urandom_range(0, 3)), 32'($urandom)};
        out_ready = ($urandom_range(0, 1) == 1);
        if (in_valid && m_in_ready() && in_op != 2'd3) pushed++;
        step();
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (!done) begin failures++; $display("FAIL rand_timeout pushed=%0d left=%0d exp drained", pushed, q.size()); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_full();
    test_illegal();
    test_reset_mid();
    test_time_gate();
    test_random_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
